// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth (>= 2), selectable standard or
// first-word-fall-through read mode, occupancy level, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
// Storage is a plain register array; pointers wrap at DEPTH-1 so the depth
// need not be a power of two.

module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int LW           = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [LW-1:0]   LVL_FULL  = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  unf_set;

    // Pointer advance with explicit wrap, so any depth works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A read needs data; a write into a full FIFO is allowed when a read
    // frees the slot in the same cycle. Flush overrides both.
    assign rd_acc  = rd && !empty;
    assign wr_acc  = wr && (!full || rd);
    assign ovf_set = !flush && wr && !wr_acc;
    assign unf_set = !flush && rd && !rd_acc;

    // Status flags decode registered level only; thresholds compare as
    // signed integers so out-of-range values saturate the flag.
    assign empty        = (level == '0);
    assign full         = (level == LVL_FULL);
    assign almost_full  = (int'(level) >= AFULL_THRESH);
    assign almost_empty = (int'(level) <= AEMPTY_THRESH);

    // Pointer and occupancy bookkeeping; flush empties the FIFO at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (unf_set)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) mem[wr_ptr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always presented; meaningless while empty.
            assign dout = mem[rd_ptr];
        end else begin : g_std
            // Registered read: data appears the cycle after an accepted rd.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                  dout <= '0;
                else if (rd_acc && !flush) dout <= mem[rd_ptr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a DEPTH=5 standard-mode instance and a DEPTH=16
// FWFT instance (thresholds 14/2), each tracked by a queue scoreboard.

module tb_sync_fifo_flex;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: DEPTH=5, standard read
    logic       a_flush, a_wr, a_rd, a_clr;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
    logic [2:0] a_level;

    // Instance B: DEPTH=16, FWFT, AFULL=14, AEMPTY=2
    logic       b_flush, b_wr, b_rd, b_clr;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf;
    logic [4:0] b_level;

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .wr(a_wr), .din(a_din),
        .full(a_full), .almost_full(a_afull), .rd(a_rd), .dout(a_dout),
        .empty(a_empty), .almost_empty(a_aempty), .level(a_level),
        .overflow(a_ovf), .underflow(a_unf), .clr_err(a_clr)
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1),
                     .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .wr(b_wr), .din(b_din),
        .full(b_full), .almost_full(b_afull), .rd(b_rd), .dout(b_dout),
        .empty(b_empty), .almost_empty(b_aempty), .level(b_level),
        .overflow(b_ovf), .underflow(b_unf), .clr_err(b_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         ma_ovf, ma_unf, mb_ovf, mb_unf;
    logic [7:0] ma_dout;

    task automatic a_cycle(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
        bit racc, wacc;
        racc = r && (qa.size() != 0);
        wacc = w && ((qa.size() != 5) || r);
        a_wr = w; a_din = d; a_rd = r; a_flush = f; a_clr = c;
        @(posedge clk); #1;
        a_wr = 0; a_rd = 0; a_flush = 0; a_clr = 0;
        if (f) qa.delete();
        else begin
            if (racc) ma_dout = qa.pop_front();
            if (wacc) qa.push_back(d);
        end
        if (!f && w && !wacc) ma_ovf = 1; else if (c) ma_ovf = 0;
        if (!f && r && !racc) ma_unf = 1; else if (c) ma_unf = 0;
        check("a_level", 32'(a_level), qa.size());
        check("a_empty", 32'(a_empty), 32'(qa.size() == 0));
        check("a_full", 32'(a_full), 32'(qa.size() == 5));
        check("a_afull", 32'(a_afull), 32'(qa.size() >= 3));
        check("a_aempty", 32'(a_aempty), 32'(qa.size() <= 2));
        check("a_dout", 32'(a_dout), 32'(ma_dout));
        check("a_ovf", 32'(a_ovf), 32'(ma_ovf));
        check("a_unf", 32'(a_unf), 32'(ma_unf));
    endtask

    task automatic b_cycle(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
        bit racc, wacc;
        racc = r && (qb.size() != 0);
        wacc = w && ((qb.size() != 16) || r);
        b_wr = w; b_din = d; b_rd = r; b_flush = f; b_clr = c;
        #1;
        if (racc) check("b_head_before_rd", 32'(b_dout), 32'(qb[0]));
        @(posedge clk); #1;
        b_wr = 0; b_rd = 0; b_flush = 0; b_clr = 0;
        if (f) qb.delete();
        else begin
            if (racc) void'(qb.pop_front());
            if (wacc) qb.push_back(d);
        end
        if (!f && w && !wacc) mb_ovf = 1; else if (c) mb_ovf = 0;
        if (!f && r && !racc) mb_unf = 1; else if (c) mb_unf = 0;
        check("b_level", 32'(b_level), qb.size());
        check("b_empty", 32'(b_empty), 32'(qb.size() == 0));
        check("b_full", 32'(b_full), 32'(qb.size() == 16));
        check("b_afull", 32'(b_afull), 32'(qb.size() >= 14));
        check("b_aempty", 32'(b_aempty), 32'(qb.size() <= 2));
        check("b_ovf", 32'(b_ovf), 32'(mb_ovf));
        check("b_unf", 32'(b_unf), 32'(mb_unf));
        if (qb.size() != 0) check("b_fwft_head", 32'(b_dout), 32'(qb[0]));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a_level"}, 32'(a_level), 0);
        check({tag, "_a_empty"}, 32'(a_empty), 1);
        check({tag, "_a_full"}, 32'(a_full), 0);
        check({tag, "_a_aempty"}, 32'(a_aempty), 1);
        check({tag, "_a_afull"}, 32'(a_afull), 0);
        check({tag, "_a_dout"}, 32'(a_dout), 0);
        check({tag, "_a_ovf"}, 32'(a_ovf), 0);
        check({tag, "_a_unf"}, 32'(a_unf), 0);
        check({tag, "_b_level"}, 32'(b_level), 0);
        check({tag, "_b_empty"}, 32'(b_empty), 1);
        check({tag, "_b_afull"}, 32'(b_afull), 0);
        check({tag, "_b_ovf"}, 32'(b_ovf), 0);
        qa.delete(); qb.delete();
        ma_ovf = 0; ma_unf = 0; mb_ovf = 0; mb_unf = 0; ma_dout = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] held;
        rst = 1;
        a_flush = 0; a_wr = 0; a_rd = 0; a_clr = 0; a_din = 0;
        b_flush = 0; b_wr = 0; b_rd = 0; b_clr = 0; b_din = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0");
        @(negedge clk) rst = 0;

        // Fill DEPTH=5, then overflow, then drain in order
        for (int i = 0; i < 5; i++) a_cycle(1, 8'(8'h11 + i), 0, 0, 0);
        a_cycle(1, 8'h16, 0, 0, 0);
        for (int i = 0; i < 5; i++) a_cycle(0, 8'h00, 1, 0, 0);
        a_cycle(0, 8'h00, 0, 0, 1);

        // Read+write on empty: underflow, write accepted
        a_cycle(1, 8'h3C, 1, 0, 0);
        a_cycle(0, 8'h00, 1, 0, 0);
        a_cycle(0, 8'h00, 0, 0, 1);
        a_cycle(0, 8'h00, 1, 0, 1);
        a_cycle(0, 8'h00, 0, 0, 1);

        // Full with simultaneous read and write on DEPTH=5
        for (int i = 0; i < 5; i++) a_cycle(1, 8'(8'h21 + i), 0, 0, 0);
        a_cycle(1, 8'h2F, 1, 0, 0);
        for (int i = 0; i < 5; i++) a_cycle(0, 8'h00, 1, 0, 0);

        // Random interleaving across many pointer wraps
        for (int i = 0; i < 80; i++)
            a_cycle(1'($urandom_range(0, 1)), 8'(8'h40 + i), 1'($urandom_range(0, 1)), 0, 0);
        for (int i = 0; i < 5; i++) a_cycle(0, 8'h00, 1, 0, 0);
        a_cycle(0, 8'h00, 0, 0, 1);

        // Flush at level 4 with a write pending; dout must hold
        for (int i = 0; i < 4; i++) a_cycle(1, 8'(8'h60 + i), 0, 0, 0);
        a_cycle(0, 8'h00, 1, 0, 0);
        a_cycle(1, 8'h64, 0, 0, 0);
        held = ma_dout;
        a_cycle(1, 8'h99, 1, 1, 0);
        check("flush_dout_hold", 32'(a_dout), 32'(held));

        // Asynchronous reset between clock edges
        for (int i = 0; i < 3; i++) a_cycle(1, 8'(8'h70 + i), 0, 0, 0);
        a_cycle(0, 8'h00, 1, 0, 0);
        b_cycle(1, 8'h55, 0, 0, 0);
        #2 rst = 1;
        #1 check_reset("async_rst");
        @(negedge clk) rst = 0;

        // FWFT: write into empty shows the word next cycle without rd
        b_cycle(1, 8'hA5, 0, 0, 0);
        check("fwft_a5", 32'(b_dout), 32'h0A5);
        b_cycle(0, 8'h00, 1, 0, 0);

        // Fill 0 -> 16 watching thresholds, then wr+rd at full, then drain
        for (int i = 0; i < 16; i++) b_cycle(1, 8'(8'hB0 + i), 0, 0, 0);
        b_cycle(1, 8'hEE, 1, 0, 0);
        for (int i = 0; i < 15; i++) b_cycle(0, 8'h00, 1, 0, 0);
        check("b_new_word_last", 32'(b_dout), 32'h0EE);
        b_cycle(0, 8'h00, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
